mem_sram_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the execute stage's ALU result as the byte address, val_Rm as store data, and the MEM_R_EN/MEM_W_EN controls.
- Performs 32-bit loads and stores to an external 16-bit SRAM as two halfword accesses.
- Drives a ready signal; the hazard/freeze logic uses it to stall all upstream pipeline registers until the access completes.

---
 rtl/mem_sram_stage_if.sv | 25 ++
 rtl/mem_sram_stage.sv | 94 +++++++++
 tb/tb_mem_sram_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_stage_if.sv
// Bundle between the pipeline memory stage and the 16-bit external SRAM:
// the request/ready side toward execute plus the SRAM pin side.
interface mem_sram_stage_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_sram_stage.sv
// Pipeline memory stage: splits each 32-bit load/store into two timed
// halfword SRAM accesses and holds ready low so upstream freezes meanwhile.
module mem_sram_stage #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic           clk,
  input  logic           rst,
  mem_sram_stage_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  count;
  logic        is_write;
  logic [16:0] word;
  logic [15:0] wdata_hi;
  logic        request;
  logic [16:0] req_word;

  assign request  = bus.rd_en | bus.wr_en;
  // Wrapping subtract; only the low 17 word bits reach the SRAM.
  assign req_word = 17'((bus.address - ADDR_BASE) >> 2);

  assign bus.ready = ((state == IDLE) & ~request) | (state == DONE);

  // SRAM pins are registered and set up on the edge entering each phase,
  // so we_n/oe/addr are stable for every cycle of LO and HI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      count           <= '0;
      is_write        <= 1'b0;
      word            <= '0;
      wdata_hi        <= '0;
      bus.read_data   <= '0;
      bus.sram_addr   <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe  <= 1'b0;
      bus.sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            state           <= LO;
            count           <= RELOAD;
            is_write        <= bus.wr_en;
            word            <= req_word;
            wdata_hi        <= bus.write_data[31:16];
            bus.sram_addr   <= {req_word, 1'b0};
            bus.sram_dq_out <= bus.write_data[15:0];
            bus.sram_dq_oe  <= bus.wr_en;
            bus.sram_we_n   <= ~bus.wr_en;
          end
        end
        LO: begin
          if (count == 4'd0) begin
            if (!is_write) begin
              bus.read_data[15:0] <= bus.sram_dq_in;
            end
            state           <= HI;
            count           <= RELOAD;
            bus.sram_addr   <= {word, 1'b1};
            bus.sram_dq_out <= wdata_hi;
          end else begin
            count <= count - 4'd1;
          end
        end
        HI: begin
          if (count == 4'd0) begin
            if (!is_write) begin
              bus.read_data[31:16] <= bus.sram_dq_in;
            end
            state          <= DONE;
            bus.sram_dq_oe <= 1'b0;
            bus.sram_we_n  <= 1'b1;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Directed bench for mem_sram_stage: vector table over a halfword SRAM model,
// plus held back-to-back loads, reset mid-store and a WAIT_CYCLES=1 instance.
module tb_mem_sram_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_sram_stage_if bus_slow ();
  mem_sram_stage_if bus_fast ();

  mem_sram_stage #(.WAIT_CYCLES(2), .ADDR_BASE(32'd1024)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_slow.slave)
  );

  mem_sram_stage #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut_fast (
    .clk(clk),
    .rst(rst),
    .bus(bus_fast.slave)
  );

  logic [15:0] sram_mem [64];

  assign bus_slow.sram_dq_in = sram_mem[bus_slow.sram_addr[5:0]];
  assign bus_fast.sram_dq_in = bus_fast.sram_addr[15:0] + 16'h1000;

  always @(posedge clk) begin
    if (!bus_slow.sram_we_n && bus_slow.sram_dq_oe) begin
      sram_mem[bus_slow.sram_addr[5:0]] <= bus_slow.sram_dq_out;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_read;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [11];

  int checks = 0;
  int errors = 0;

  int          low_cycles;
  int          we_low;
  int          remaining;
  logic [17:0] addr_lo;
  logic [17:0] addr_hi;
  logic [15:0] dq_lo;
  logic [15:0] dq_hi;
  logic        done_we_n;
  logic [31:0] rdata;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request and watches the freeze window until ready returns.
  // Phase samples are taken at low cycle 1 (first LO) and 3 (first HI).
  task automatic apply_stimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    bus_slow.rd_en      = rd;
    bus_slow.wr_en      = wr;
    bus_slow.address    = addr;
    bus_slow.write_data = data;
    low_cycles = 0;
    we_low     = 0;
    addr_lo    = '0;
    addr_hi    = '0;
    dq_lo      = '0;
    dq_hi      = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_slow.ready) break;
      if (!bus_slow.sram_we_n) we_low++;
      if (low_cycles == 1) begin
        addr_lo = bus_slow.sram_addr;
        dq_lo   = bus_slow.sram_dq_out;
      end
      if (low_cycles == 3) begin
        addr_hi = bus_slow.sram_addr;
        dq_hi   = bus_slow.sram_dq_out;
      end
      low_cycles++;
    end
    done_we_n = bus_slow.sram_we_n;
    rdata     = bus_slow.read_data;
  endtask

  task automatic idle_inputs();
    @(posedge clk);
    #1;
    bus_slow.rd_en = 1'b0;
    bus_slow.wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000, 18'h00004};
    vecs[1]  = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF, 18'h00004};
    vecs[2]  = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 18'h00000};
    vecs[3]  = '{1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'hDEADBEEF, 18'h00002};
    vecs[4]  = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h12345678, 18'h00000};
    vecs[5]  = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'hCAFEF00D, 18'h00002};
    vecs[6]  = '{1'b1, 1'b0, 32'd1027, 32'h00000000, 32'h12345678, 18'h00000};
    vecs[7]  = '{1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, 32'h12345678, 18'h00006};
    vecs[8]  = '{1'b1, 1'b0, 32'd1036, 32'h00000000, 32'hA5A55A5A, 18'h00006};
    vecs[9]  = '{1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 32'hA5A55A5A, 18'h3FFFE};
    vecs[10] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 32'h0BADC0DE, 18'h3FFFE};

    rst = 1'b0;
    bus_slow.rd_en = 1'b0;  bus_slow.wr_en = 1'b0;
    bus_slow.address = '0;  bus_slow.write_data = '0;
    bus_fast.rd_en = 1'b0;  bus_fast.wr_en = 1'b0;
    bus_fast.address = '0;  bus_fast.write_data = '0;

    repeat (2) @(negedge clk);
    check_output("reset_ready", 32'(bus_slow.ready), 32'd1);
    check_output("reset_we_n", 32'(bus_slow.sram_we_n), 32'd1);
    check_output("reset_oe", 32'(bus_slow.sram_dq_oe), 32'd0);
    check_output("reset_addr", 32'(bus_slow.sram_addr), 32'd0);
    check_output("reset_dq_out", 32'(bus_slow.sram_dq_out), 32'd0);
    check_output("reset_read_data", bus_slow.read_data, 32'd0);
    check_output("reset_fast_ready", 32'(bus_fast.ready), 32'd1);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      check_output($sformatf("v%0d_freeze", i), 32'(low_cycles), 32'd5);
      check_output($sformatf("v%0d_we_low", i), 32'(we_low), vecs[i].wr ? 32'd4 : 32'd0);
      check_output($sformatf("v%0d_addr_lo", i), 32'(addr_lo), 32'(vecs[i].exp_lo));
      check_output($sformatf("v%0d_addr_hi", i), 32'(addr_hi), 32'(vecs[i].exp_lo | 18'd1));
      check_output($sformatf("v%0d_done_we_n", i), 32'(done_we_n), 32'd1);
      check_output($sformatf("v%0d_read_data", i), rdata, vecs[i].exp_read);
      if (vecs[i].wr) begin
        check_output($sformatf("v%0d_dq_lo", i), 32'(dq_lo), 32'(vecs[i].data[15:0]));
        check_output($sformatf("v%0d_dq_hi", i), 32'(dq_hi), 32'(vecs[i].data[31:16]));
      end
      idle_inputs();
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("idle_%0d", i),
                   32'({bus_slow.ready, bus_slow.sram_we_n, bus_slow.sram_dq_oe}), 32'b110);
    end

    // Held requests: the second load is presented right after the DONE edge.
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'd0);
    check_output("held_a_freeze", 32'(low_cycles), 32'd5);
    check_output("held_a_addr_lo", 32'(addr_lo), 32'd0);
    check_output("held_a_addr_hi", 32'(addr_hi), 32'd1);
    check_output("held_a_read", rdata, 32'h12345678);
    apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0);
    check_output("held_b_freeze", 32'(low_cycles), 32'd5);
    check_output("held_b_addr_lo", 32'(addr_lo), 32'd2);
    check_output("held_b_addr_hi", 32'(addr_hi), 32'd3);
    check_output("held_b_read", rdata, 32'hCAFEF00D);
    idle_inputs();

    // Reset during the HI phase of a store, request still held.
    @(posedge clk);
    #1;
    bus_slow.wr_en      = 1'b1;
    bus_slow.address    = 32'd1032;
    bus_slow.write_data = 32'h11223344;
    repeat (4) @(negedge clk);
    check_output("rst_pre_addr", 32'(bus_slow.sram_addr), 32'd5);
    check_output("rst_pre_we_n", 32'(bus_slow.sram_we_n), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_we_n", 32'(bus_slow.sram_we_n), 32'd1);
    check_output("rst_oe", 32'(bus_slow.sram_dq_oe), 32'd0);
    check_output("rst_ready", 32'(bus_slow.ready), 32'd0);
    check_output("rst_read_data", bus_slow.read_data, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("restart_ready", 32'(bus_slow.ready), 32'd0);
    check_output("restart_addr", 32'(bus_slow.sram_addr), 32'd4);
    check_output("restart_we_n", 32'(bus_slow.sram_we_n), 32'd0);
    check_output("restart_dq", 32'(bus_slow.sram_dq_out), 32'h3344);
    remaining = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_slow.ready) break;
      remaining++;
    end
    check_output("restart_remaining", 32'(remaining), 32'd3);
    idle_inputs();
    apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0);
    check_output("restart_readback", rdata, 32'h11223344);
    idle_inputs();

    // WAIT_CYCLES=1 instance: one cycle per phase.
    @(posedge clk);
    #1;
    bus_fast.rd_en   = 1'b1;
    bus_fast.address = 32'd1036;
    low_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_fast.ready) break;
      low_cycles++;
    end
    check_output("fast_freeze", 32'(low_cycles), 32'd3);
    check_output("fast_read", bus_fast.read_data, 32'h10071006);
    @(posedge clk);
    #1;
    bus_fast.rd_en = 1'b0;
    @(negedge clk);
    check_output("fast_idle_ready", 32'(bus_fast.ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
